// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encodings, default register-index width and the event priority order.
package hazard_pkg;

    localparam int REG_W = 3;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        BUBBLE = 2'b01,
        FREEZE = 2'b10
    } state_e;

    // Events that steer the pipeline in a cycle; a larger encoding wins
    // when several are present at once.
    typedef enum logic [2:0] {
        EV_NONE     = 3'd0,
        EV_JUMP     = 3'd1,
        EV_LOAD_USE = 3'd2,
        EV_BRANCH   = 3'd3,
        EV_MEM_BUSY = 3'd4
    } event_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // Clear wins over increment; the count never wraps past all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump squashes and
// memory-busy freezes, plus stall statistics and a freeze watchdog.
module hazard_ctrl #(
    parameter int REG_W   = hazard_pkg::REG_W,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic             id_ex_mem_read,
    input  logic             branch_taken,
    input  logic             jump_id,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             timeout_err
);

    import hazard_pkg::*;

    // Wide enough to hold TIMEOUT itself.
    localparam int FZ_W = $clog2(TIMEOUT + 1);

    state_e          cur_state;
    state_e          next_state;
    event_e          ev;
    logic            load_use;
    logic            in_freeze;
    logic [FZ_W-1:0] freeze_cnt;

    // A load in EX feeding a register the ID instruction reads; r0 never stalls.
    always_comb begin
        load_use = id_ex_mem_read && (id_ex_rd != '0) &&
                   ((id_ex_rd == if_id_rs) || (if_id_uses_rt && (id_ex_rd == if_id_rt)));
    end

    // Pick the single highest-priority event; BUBBLE ignores load-use.
    always_comb begin
        ev = EV_NONE;
        if (mem_busy) begin
            ev = EV_MEM_BUSY;
        end else if (branch_taken) begin
            ev = EV_BRANCH;
        end else if (load_use && (cur_state != BUBBLE)) begin
            ev = EV_LOAD_USE;
        end else if (jump_id) begin
            ev = EV_JUMP;
        end
    end

    // Control outputs and next state; reset forces every control output low.
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        next_state    = RUN;
        case (ev)
            EV_MEM_BUSY: begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_write   = 1'b0;
                ex_mem_write  = 1'b0;
                mem_wb_bubble = 1'b1;
                next_state    = FREEZE;
            end
            EV_BRANCH: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
            EV_LOAD_USE: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                next_state  = BUBBLE;
            end
            EV_JUMP: begin
                if_id_flush = 1'b1;
            end
            default: begin
            end
        endcase
        if (reset) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            if_id_flush   = 1'b0;
            id_ex_flush   = 1'b0;
            mem_wb_bubble = 1'b0;
            next_state    = RUN;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= RUN;
        end else begin
            cur_state <= next_state;
        end
    end

    assign state     = cur_state;
    assign in_freeze = (cur_state == FREEZE);

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!pc_write),
        .clr   (1'b0),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(FZ_W)) u_freeze_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (in_freeze),
        .clr   (!in_freeze),
        .count (freeze_cnt)
    );

    // Sticky watchdog: set on the edge where the freeze count reaches TIMEOUT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if (in_freeze && (freeze_cnt == FZ_W'(TIMEOUT - 1))) begin
            timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random
// stimulus against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int REG_W     = 3;
    localparam int TIMEOUT   = 4;
    localparam int CNT_W     = 6;
    localparam int STALL_MAX = (1 << CNT_W) - 1;

    localparam logic [6:0] O_IDLE   = 7'b1111000;
    localparam logic [6:0] O_LU     = 7'b0011010;
    localparam logic [6:0] O_BRANCH = 7'b1111110;
    localparam logic [6:0] O_JUMP   = 7'b1111100;
    localparam logic [6:0] O_BUSY   = 7'b0000001;
    localparam logic [6:0] O_RESET  = 7'b0000000;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] if_id_rs, if_id_rt, id_ex_rd;
    logic             if_id_uses_rt, id_ex_mem_read, branch_taken, jump_id, mem_busy;
    logic             pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic             if_id_flush, id_ex_flush, mem_wb_bubble;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cycles;
    logic             timeout_err;
    logic [6:0]       obs;

    int         checks = 0;
    int         errors = 0;
    int         m_state, m_stall, m_freeze, exp_next;
    bit         m_err;
    logic [6:0] exp_out;

    always #5 clk = ~clk;

    assign obs = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                  if_id_flush, id_ex_flush, mem_wb_bubble};

    hazard_ctrl #(.REG_W(REG_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_id_rs       (if_id_rs),
        .if_id_rt       (if_id_rt),
        .if_id_uses_rt  (if_id_uses_rt),
        .id_ex_rd       (id_ex_rd),
        .id_ex_mem_read (id_ex_mem_read),
        .branch_taken   (branch_taken),
        .jump_id        (jump_id),
        .mem_busy       (mem_busy),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .id_ex_write    (id_ex_write),
        .ex_mem_write   (ex_mem_write),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .mem_wb_bubble  (mem_wb_bubble),
        .state          (state),
        .stall_cycles   (stall_cycles),
        .timeout_err    (timeout_err)
    );

    function automatic void model_clear();
        m_state  = 0;
        m_stall  = 0;
        m_freeze = 0;
        m_err    = 0;
    endfunction

    // Rule table: which outputs the current inputs and mode call for.
    function automatic void model_eval();
        bit lu;
        lu = id_ex_mem_read && (id_ex_rd != 0) &&
             (id_ex_rd == if_id_rs || (if_id_uses_rt && id_ex_rd == if_id_rt));
        exp_next = 0;
        if (reset) begin
            exp_out = O_RESET;
        end else if (mem_busy) begin
            exp_out  = O_BUSY;
            exp_next = 2;
        end else if (branch_taken) begin
            exp_out = O_BRANCH;
        end else if (lu && m_state != 1) begin
            exp_out  = O_LU;
            exp_next = 1;
        end else if (jump_id) begin
            exp_out = O_JUMP;
        end else begin
            exp_out = O_IDLE;
        end
    endfunction

    task automatic set_idle();
        if_id_rs = 0; if_id_rt = 0; id_ex_rd = 0;
        if_id_uses_rt = 0; id_ex_mem_read = 0;
        branch_taken = 0; jump_id = 0; mem_busy = 0;
    endtask

    task automatic set_load_use(input int r);
        id_ex_mem_read = 1;
        id_ex_rd = REG_W'(r);
        if_id_rs = REG_W'(r);
    endtask

    // One clock edge, advancing the model with the inputs held across it.
    task automatic advance();
        model_eval();
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            if (!exp_out[6] && m_stall < STALL_MAX) m_stall++;
            if (m_state == 2) begin
                m_freeze++;
                if (m_freeze >= TIMEOUT) m_err = 1;
            end else begin
                m_freeze = 0;
            end
            m_state = exp_next;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        set_idle();
        #1;
        model_clear();
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        set_idle();
        #2;
        checks++;
        if (obs !== O_RESET || state !== 2'b00 || stall_cycles !== '0 || timeout_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_async got out=%b st=%b stall=%0d err=%b want out=%b st=00 stall=0 err=0",
                     obs, state, stall_cycles, timeout_err, O_RESET);
        end
        model_clear();
        @(posedge clk);
        #1;
        reset = 0;
        #1;
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("[TB] FAIL reset_release_idle got %b want %b", obs, O_IDLE);
        end
        advance();
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use(3);
        #1;
        checks++;
        if (obs !== O_LU) begin
            errors++;
            $display("[TB] FAIL lu_out got %b want %b", obs, O_LU);
        end
        advance();
        set_idle();
        #1;
        checks++;
        if (state !== 2'b01 || obs !== O_IDLE) begin
            errors++;
            $display("[TB] FAIL lu_bubble got st=%b out=%b want st=01 out=%b", state, obs, O_IDLE);
        end
        advance();
        checks++;
        if (state !== 2'b00 || stall_cycles !== CNT_W'(1)) begin
            errors++;
            $display("[TB] FAIL lu_after got st=%b stall=%0d want st=00 stall=1", state, stall_cycles);
        end
        // Load-use held into BUBBLE is not re-evaluated there.
        set_load_use(4);
        #1;
        advance();
        #1;
        checks++;
        if (state !== 2'b01 || obs !== O_IDLE) begin
            errors++;
            $display("[TB] FAIL lu_held_in_bubble got st=%b out=%b want st=01 out=%b", state, obs, O_IDLE);
        end
        advance();
        set_idle();
    endtask

    task automatic test_rt_gating();
        do_reset();
        id_ex_mem_read = 1; id_ex_rd = 5; if_id_rt = 5; if_id_rs = 1; if_id_uses_rt = 0;
        #1;
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("[TB] FAIL rt_unused got %b want %b", obs, O_IDLE);
        end
        if_id_uses_rt = 1;
        #1;
        checks++;
        if (obs !== O_LU) begin
            errors++;
            $display("[TB] FAIL rt_used got %b want %b", obs, O_LU);
        end
        id_ex_rd = 0; if_id_rt = 0; if_id_rs = 0;
        #1;
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("[TB] FAIL r0_no_stall got %b want %b", obs, O_IDLE);
        end
        advance();
        set_idle();
    endtask

    task automatic test_branch_jump();
        do_reset();
        set_load_use(2);
        branch_taken = 1;
        jump_id = 1;
        #1;
        checks++;
        if (obs !== O_BRANCH) begin
            errors++;
            $display("[TB] FAIL branch_over_lu got %b want %b", obs, O_BRANCH);
        end
        advance();
        checks++;
        if (state !== 2'b00) begin
            errors++;
            $display("[TB] FAIL branch_state got %b want 00", state);
        end
        set_idle();
        jump_id = 1;
        #1;
        checks++;
        if (obs !== O_JUMP) begin
            errors++;
            $display("[TB] FAIL jump_out got %b want %b", obs, O_JUMP);
        end
        set_load_use(6);
        #1;
        checks++;
        if (obs !== O_LU) begin
            errors++;
            $display("[TB] FAIL jump_deferred got %b want %b", obs, O_LU);
        end
        advance();
        set_idle();
    endtask

    task automatic test_freeze();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            mem_busy = 1;
            #1;
            checks++;
            if (obs !== O_BUSY) begin
                errors++;
                $display("[TB] FAIL freeze_out[%0d] got %b want %b", i, obs, O_BUSY);
            end
            advance();
            checks++;
            if (state !== 2'b10) begin
                errors++;
                $display("[TB] FAIL freeze_state[%0d] got %b want 10", i, state);
            end
        end
        mem_busy = 0;
        #1;
        checks++;
        if (obs !== O_IDLE || stall_cycles !== CNT_W'(3)) begin
            errors++;
            $display("[TB] FAIL freeze_release got out=%b stall=%0d want out=%b stall=3", obs, stall_cycles, O_IDLE);
        end
        advance();
        checks++;
        if (state !== 2'b00) begin
            errors++;
            $display("[TB] FAIL freeze_exit got %b want 00", state);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            mem_busy = 1;
            #1;
            advance();
            checks++;
            if (timeout_err !== (i >= 5)) begin
                errors++;
                $display("[TB] FAIL timeout_rise[%0d] got %b want %b", i, timeout_err, (i >= 5));
            end
        end
        mem_busy = 0;
        #1;
        advance();
        advance();
        checks++;
        if (timeout_err !== 1'b1 || state !== 2'b00) begin
            errors++;
            $display("[TB] FAIL timeout_sticky got err=%b st=%b want err=1 st=00", timeout_err, state);
        end
        reset = 1;
        #1;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_reset got %b want 0", timeout_err);
        end
        model_clear();
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic test_reset_mid_bubble();
        do_reset();
        set_load_use(3);
        #1;
        advance();
        checks++;
        if (state !== 2'b01) begin
            errors++;
            $display("[TB] FAIL rmb_in_bubble got %b want 01", state);
        end
        reset = 1;
        #1;
        checks++;
        if (obs !== O_RESET || state !== 2'b00 || stall_cycles !== '0) begin
            errors++;
            $display("[TB] FAIL rmb_immediate got out=%b st=%b stall=%0d want out=%b st=00 stall=0",
                     obs, state, stall_cycles, O_RESET);
        end
        model_clear();
        @(posedge clk);
        #1;
        reset = 0;
        set_idle();
        #1;
        checks++;
        if (obs !== O_IDLE || state !== 2'b00) begin
            errors++;
            $display("[TB] FAIL rmb_after got out=%b st=%b want out=%b st=00", obs, state, O_IDLE);
        end
        advance();
    endtask

    task automatic test_saturation();
        do_reset();
        mem_busy = 1;
        for (int i = 0; i < STALL_MAX + 6; i++) begin
            #1;
            advance();
        end
        checks++;
        if (stall_cycles !== CNT_W'(STALL_MAX)) begin
            errors++;
            $display("[TB] FAIL stall_saturate got %0d want %0d", stall_cycles, STALL_MAX);
        end
        mem_busy = 0;
        #1;
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            mem_busy       = ($urandom_range(0, 7) == 0);
            branch_taken   = ($urandom_range(0, 7) == 0);
            jump_id        = ($urandom_range(0, 5) == 0);
            id_ex_mem_read = $urandom_range(0, 1);
            if_id_uses_rt  = $urandom_range(0, 1);
            id_ex_rd       = REG_W'($urandom_range(0, 3));
            if_id_rs       = REG_W'($urandom_range(0, 3));
            if_id_rt       = REG_W'($urandom_range(0, 3));
            #1;
            model_eval();
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("[TB] FAIL rand_out[%0d] got %b want %b", i, obs, exp_out);
            end
            advance();
            checks++;
            if (state !== 2'(m_state) || stall_cycles !== CNT_W'(m_stall) || timeout_err !== m_err) begin
                errors++;
                $display("[TB] FAIL rand_regs[%0d] got st=%b stall=%0d err=%b want st=%0d stall=%0d err=%b",
                         i, state, stall_cycles, timeout_err, m_state, m_stall, m_err);
            end
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        test_reset();
        test_load_use();
        test_rt_gating();
        test_branch_jump();
        test_freeze();
        test_timeout();
        test_reset_mid_bubble();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameters SHALL be, one per line as name, default, meaning:
- REG_W, 3, register-index width.
- TIMEOUT, 64, consecutive freeze cycles before error.
- CNT_W, 16, stall-counter width.
REQ-003 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  clock.
- reset  in  1  async active-high reset.
- if_id_rs  in  REG_W  source register of the instruction in ID.
- if_id_rt  in  REG_W  target register of the instruction in ID.
- if_id_uses_rt  in  1  ID instruction reads rt.
- id_ex_rd  in  REG_W  destination register in EX.
- id_ex_mem_read  in  1  EX instruction is a load.
- branch_taken  in  1  EX branch resolved taken.
- jump_id  in  1  jump decoded in ID.
- mem_busy  in  1  data memory not ready; pipeline must hold.
- pc_write, if_id_write, id_ex_write, ex_mem_write  out  1 each  stage write enables.
- if_id_flush, id_ex_flush  out  1 each  squash stage contents to NOP.
- mem_wb_bubble  out  1  insert NOP into MEM/WB.
- state  out  2  FSM state.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0.
- timeout_err  out  1  sticky freeze-timeout flag.

Function
REQ-004 The FSM states SHALL be RUN=00, BUBBLE=01 and FREEZE=10; control outputs SHALL be combinational in state and inputs, and the same cycle as the hazard.
REQ-005 Event priority SHALL be mem_busy > branch_taken > load-use > jump_id.
REQ-006 While mem_busy=1, in any state:
- all four write enables SHALL be 0, both flushes 0, and mem_wb_bubble=1;
- next state SHALL be FREEZE.
REQ-007 In FREEZE with mem_busy=0, outputs SHALL be evaluated as in RUN for that cycle, and next state SHALL follow the RUN rules.
REQ-008 Branch: with branch_taken=1 and mem_busy=0:
- if_id_flush=1, id_ex_flush=1 and pc_write=1;
- load-use and jump SHALL be ignored;
- next state SHALL be RUN.
REQ-009 A load-use hazard SHALL be the condition id_ex_mem_read=1, id_ex_rd!=0, and either id_ex_rd==if_id_rs or (if_id_uses_rt=1 and id_ex_rd==if_id_rt).
REQ-010 On a load-use hazard in RUN or FREEZE, with no higher-priority event:
- pc_write=0, if_id_write=0 and id_ex_flush=1;
- next state SHALL be BUBBLE.
REQ-011 BUBBLE SHALL last exactly one cycle and then go to RUN; in BUBBLE, the load-use rule SHALL NOT be evaluated; mem_busy SHALL still take it to FREEZE.
REQ-012 Jump: with jump_id=1 and no higher-priority event, if_id_flush=1 and all writes=1; a jump coinciding with load-use SHALL be deferred, with no flush that cycle.
REQ-013 With no event, all write enables SHALL be 1, and flushes and bubble SHALL be 0.
REQ-014 stall_cycles SHALL increment by 1 in each cycle where pc_write=0, and SHALL saturate at all-ones without wrapping.
REQ-015 An internal freeze counter SHALL count consecutive FREEZE cycles, and SHALL clear to 0 on any cycle spent outside FREEZE.
REQ-016 When the freeze counter reaches TIMEOUT, timeout_err SHALL set, and SHALL stay set until reset.
REQ-017 Register index 0 SHALL never cause a stall.

Reset
REQ-018 Reset SHALL force the following, asynchronously and with no clock required:
- state=RUN, stall_cycles=0, freeze counter=0, timeout_err=0;
- all write enables and both flushes 0, and mem_wb_bubble=0, while reset is asserted.
REQ-019 A reset asserted mid-BUBBLE or mid-FREEZE SHALL abandon the sequence; the first cycle after deassertion SHALL behave as RUN.

Structure
REQ-020 The state encodings, REG_W and the event-priority constants SHALL live in the shared package hazard_pkg.
REQ-021 The stall and freeze counters SHALL each be an instance of one sub-module, sat_counter (parameterised width, inc, clr, saturating).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Load-use: id_ex_mem_read=1, id_ex_rd=3, if_id_rs=3 -> pc_write=0, if_id_write=0, id_ex_flush=1; next cycle state=BUBBLE; the cycle after, state=RUN; stall_cycles=1.
- rt gating: id_ex_rd=5, if_id_rt=5, if_id_uses_rt=0 -> no stall; with if_id_uses_rt=1 -> stall.
- Branch over load-use: branch_taken=1 together with a load-use on r2 -> both flushes=1, pc_write=1, state stays RUN.
- Freeze: mem_busy=1 for 3 cycles -> writes=0, mem_wb_bubble=1, state=FREEZE; stall_cycles +3; on release, normal outputs.
- Timeout: TIMEOUT=4, mem_busy held 6 cycles -> timeout_err rises after the 4th freeze cycle and stays 1 after mem_busy drops; reset clears it.
- Reset mid-BUBBLE: state=BUBBLE, assert reset -> all outputs 0 immediately; after release, state=RUN and counters=0.
